// File: rtl/arith_sched_pkg.sv
// Shared constants and types for the round-robin arithmetic scheduler.
package arith_sched_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_MUL = 1'b1;

    localparam int OPND_W    = 4;
    localparam int ADD_RES_W = 5;
    localparam int MUL_RES_W = 8;

    // Wide enough for the largest supported requester count (8).
    localparam int RSP_ID_W  = 3;

    typedef struct packed {
        logic                 valid;
        logic [RSP_ID_W-1:0]  id;
        logic [MUL_RES_W-1:0] data;
    } rsp_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after the pointer,
// then moves the pointer one past the winner so it drops to lowest priority.
module rr_arbiter #(
    parameter  int N  = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          any_gnt
);

    logic [IW-1:0] ptr_q, ptr_d;

    // Search from the pointer, wrapping at N-1 -> 0; first hit wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any_gnt = 1'b0;
        for (int off = 0; off < N; off++) begin
            int            idx;
            logic [IW-1:0] idx_v;
            idx = int'(ptr_q) + off;
            if (idx >= N) idx = idx - N;
            idx_v = IW'(idx);
            if (!any_gnt && req[idx_v]) begin
                any_gnt    = 1'b1;
                gnt[idx_v] = 1'b1;
                gnt_idx    = idx_v;
            end
        end
    end

    // Pointer advances only on a grant.
    always_comb begin
        ptr_d = ptr_q;
        if (any_gnt) begin
            ptr_d = (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    // Pointer register, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

endmodule

// File: rtl/arith_rr_scheduler.sv
// Shares one registered adder and one registered multiplier among NREQ
// requesters; each op class has its own round-robin arbiter and results
// are tagged with the issuing requester one cycle after acceptance.
module arith_rr_scheduler
    import arith_sched_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1,
    parameter int CNTW = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ-1:0]        req_op,
    input  logic [OPND_W*NREQ-1:0] req_a,
    input  logic [OPND_W*NREQ-1:0] req_b,
    output logic [NREQ-1:0]        req_ready,
    output logic [OPND_W-1:0]      add_a,
    output logic [OPND_W-1:0]      add_b,
    input  logic [ADD_RES_W-1:0]   add_res,
    output logic [OPND_W-1:0]      mul_a,
    output logic [OPND_W-1:0]      mul_b,
    input  logic [MUL_RES_W-1:0]   mul_res,
    output logic                   add_rsp_valid,
    output logic [IDW-1:0]         add_rsp_id,
    output logic [ADD_RES_W-1:0]   add_rsp_data,
    output logic                   mul_rsp_valid,
    output logic [IDW-1:0]         mul_rsp_id,
    output logic [MUL_RES_W-1:0]   mul_rsp_data,
    output logic [CNTW-1:0]        add_grants,
    output logic [CNTW-1:0]        mul_grants
);

    logic [NREQ-1:0] add_req, mul_req;
    logic [NREQ-1:0] add_gnt, mul_gnt;
    logic [IDW-1:0]  add_idx, mul_idx;
    logic            add_any, mul_any;

    logic            add_vld_q, add_vld_d, mul_vld_q, mul_vld_d;
    logic [IDW-1:0]  add_id_q, add_id_d, mul_id_q, mul_id_d;
    logic [CNTW-1:0] add_cnt_q, add_cnt_d, mul_cnt_q, mul_cnt_d;

    // Split requests by op; reset masks everything so nothing is accepted.
    always_comb begin
        add_req = '0;
        mul_req = '0;
        for (int i = 0; i < NREQ; i++) begin
            add_req[i] = ~rst & req_valid[i] & (req_op[i] == OP_ADD);
            mul_req[i] = ~rst & req_valid[i] & (req_op[i] == OP_MUL);
        end
    end

    rr_arbiter #(.N(NREQ)) u_add_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (add_req),
        .gnt     (add_gnt),
        .gnt_idx (add_idx),
        .any_gnt (add_any)
    );

    rr_arbiter #(.N(NREQ)) u_mul_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (mul_req),
        .gnt     (mul_gnt),
        .gnt_idx (mul_idx),
        .any_gnt (mul_any)
    );

    assign req_ready = add_gnt | mul_gnt;

    // One-hot operand mux into the units; zero when the unit is idle.
    always_comb begin
        add_a = '0;
        add_b = '0;
        mul_a = '0;
        mul_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (add_gnt[i]) begin
                add_a = req_a[OPND_W*i +: OPND_W];
                add_b = req_b[OPND_W*i +: OPND_W];
            end
            if (mul_gnt[i]) begin
                mul_a = req_a[OPND_W*i +: OPND_W];
                mul_b = req_b[OPND_W*i +: OPND_W];
            end
        end
    end

    // Response tags track the units' one-cycle latency; counters saturate.
    always_comb begin
        add_vld_d = add_any;
        add_id_d  = add_idx;
        mul_vld_d = mul_any;
        mul_id_d  = mul_idx;
        add_cnt_d = add_cnt_q;
        mul_cnt_d = mul_cnt_q;
        if (add_any && (add_cnt_q != '1)) add_cnt_d = add_cnt_q + 1'b1;
        if (mul_any && (mul_cnt_q != '1)) mul_cnt_d = mul_cnt_q + 1'b1;
    end

    // Response and counter registers; reset drops anything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            add_vld_q <= 1'b0;
            add_id_q  <= '0;
            mul_vld_q <= 1'b0;
            mul_id_q  <= '0;
            add_cnt_q <= '0;
            mul_cnt_q <= '0;
        end else begin
            add_vld_q <= add_vld_d;
            add_id_q  <= add_id_d;
            mul_vld_q <= mul_vld_d;
            mul_id_q  <= mul_id_d;
            add_cnt_q <= add_cnt_d;
            mul_cnt_q <= mul_cnt_d;
        end
    end

    assign add_rsp_valid = add_vld_q;
    assign add_rsp_id    = add_id_q;
    assign add_rsp_data  = add_res;
    assign mul_rsp_valid = mul_vld_q;
    assign mul_rsp_id    = mul_id_q;
    assign mul_rsp_data  = mul_res;
    assign add_grants    = add_cnt_q;
    assign mul_grants    = mul_cnt_q;

endmodule

// File: tb/tb_arith_rr_scheduler.sv
// Bench for arith_rr_scheduler: directed cases plus a randomized run, with
// a reference arbiter model and per-op response queues.
module tb_arith_rr_scheduler;
    import arith_sched_pkg::*;

    localparam int NREQ    = 3;
    localparam int IDW     = 2;
    localparam int CNTW    = 4;
    localparam int CNT_MAX = (1 << CNTW) - 1;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [NREQ-1:0]        req_valid = '0;
    logic [NREQ-1:0]        req_op = '0;
    logic [OPND_W*NREQ-1:0] req_a = '0;
    logic [OPND_W*NREQ-1:0] req_b = '0;
    logic [NREQ-1:0]        req_ready;
    logic [OPND_W-1:0]      add_a, add_b, mul_a, mul_b;
    logic [ADD_RES_W-1:0]   add_res;
    logic [MUL_RES_W-1:0]   mul_res;
    logic                   add_rsp_valid, mul_rsp_valid;
    logic [IDW-1:0]         add_rsp_id, mul_rsp_id;
    logic [ADD_RES_W-1:0]   add_rsp_data;
    logic [MUL_RES_W-1:0]   mul_rsp_data;
    logic [CNTW-1:0]        add_grants, mul_grants;

    int n_cmp = 0;
    int n_bad = 0;

    arith_rr_scheduler #(.NREQ(NREQ), .IDW(IDW), .CNTW(CNTW)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_op        (req_op),
        .req_a         (req_a),
        .req_b         (req_b),
        .req_ready     (req_ready),
        .add_a         (add_a),
        .add_b         (add_b),
        .add_res       (add_res),
        .mul_a         (mul_a),
        .mul_b         (mul_b),
        .mul_res       (mul_res),
        .add_rsp_valid (add_rsp_valid),
        .add_rsp_id    (add_rsp_id),
        .add_rsp_data  (add_rsp_data),
        .mul_rsp_valid (mul_rsp_valid),
        .mul_rsp_id    (mul_rsp_id),
        .mul_rsp_data  (mul_rsp_data),
        .add_grants    (add_grants),
        .mul_grants    (mul_grants)
    );

    always #5 clk = ~clk;

    // Registered adder/multiplier units the scheduler feeds.
    always_ff @(posedge clk) begin
        add_res <= {1'b0, add_a} + {1'b0, add_b};
        mul_res <= {4'b0, mul_a} * {4'b0, mul_b};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int pick(input logic [NREQ-1:0] r, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j = (ptr + k) % NREQ;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    // Reference state
    rsp_t add_q[$];
    rsp_t mul_q[$];
    int   m_ptr_add = 0, m_ptr_mul = 0;
    int   m_add_cnt = 0, m_mul_cnt = 0;
    int   wait_cnt[NREQ];
    bit   mon_en = 0, rnd_en = 0;
    logic [NREQ-1:0] acc_seen = '0;
    logic [NREQ-1:0] prev_valid = '0, prev_ready = '0;
    logic [9:0]      prev_req[NREQ];
    logic [NREQ-1:0] m_add_req, m_mul_req, exp_rdy, dut_acc;
    int   ga, gm;
    rsp_t e;

    initial for (int i = 0; i < NREQ; i++) begin
        wait_cnt[i] = 0;
        prev_req[i] = '0;
    end

    // Monitor: compares responses, grants, operands and counters each cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            if (rnd_en) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (prev_valid[i] && !prev_ready[i])
                        chk("hold_rule", {req_valid[i], req_op[i], req_a[4*i +: 4], req_b[4*i +: 4]},
                            prev_req[i]);
                end
            end

            chk("add_grants", add_grants, m_add_cnt);
            chk("mul_grants", mul_grants, m_mul_cnt);

            chk("add_rsp_valid", add_rsp_valid, (add_q.size() > 0) ? add_q[0].valid : 1'b0);
            if (add_q.size() > 0) begin
                e = add_q.pop_front();
                if (add_rsp_valid) begin
                    chk("add_rsp_id", add_rsp_id, e.id);
                    chk("add_rsp_data", add_rsp_data, e.data);
                end
            end
            chk("mul_rsp_valid", mul_rsp_valid, (mul_q.size() > 0) ? mul_q[0].valid : 1'b0);
            if (mul_q.size() > 0) begin
                e = mul_q.pop_front();
                if (mul_rsp_valid) begin
                    chk("mul_rsp_id", mul_rsp_id, e.id);
                    chk("mul_rsp_data", mul_rsp_data, e.data);
                end
            end

            m_add_req = req_valid & ~req_op;
            m_mul_req = req_valid & req_op;
            ga = rst ? -1 : pick(m_add_req, m_ptr_add);
            gm = rst ? -1 : pick(m_mul_req, m_ptr_mul);
            exp_rdy = '0;
            if (ga >= 0) exp_rdy[ga] = 1'b1;
            if (gm >= 0) exp_rdy[gm] = 1'b1;
            chk("req_ready", req_ready, exp_rdy);
            chk("add_a", add_a, (ga >= 0) ? req_a[4*ga +: 4] : 4'd0);
            chk("add_b", add_b, (ga >= 0) ? req_b[4*ga +: 4] : 4'd0);
            chk("mul_a", mul_a, (gm >= 0) ? req_a[4*gm +: 4] : 4'd0);
            chk("mul_b", mul_b, (gm >= 0) ? req_b[4*gm +: 4] : 4'd0);

            dut_acc = req_ready & req_valid;
            if (rst) begin
                m_ptr_add = 0;
                m_ptr_mul = 0;
                m_add_cnt = 0;
                m_mul_cnt = 0;
                for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;
            end else begin
                if (ga >= 0) begin
                    add_q.push_back('{valid: 1'b1, id: 3'(ga),
                                      data: 8'(req_a[4*ga +: 4]) + 8'(req_b[4*ga +: 4])});
                    m_ptr_add = (ga + 1) % NREQ;
                    if (m_add_cnt < CNT_MAX) m_add_cnt++;
                end
                if (gm >= 0) begin
                    mul_q.push_back('{valid: 1'b1, id: 3'(gm),
                                      data: 8'(req_a[4*gm +: 4]) * 8'(req_b[4*gm +: 4])});
                    m_ptr_mul = (gm + 1) % NREQ;
                    if (m_mul_cnt < CNT_MAX) m_mul_cnt++;
                end
                for (int i = 0; i < NREQ; i++) begin
                    if (dut_acc[i]) begin
                        if (rnd_en) chk("starve_ok", 32'(wait_cnt[i] < NREQ), 32'd1);
                        wait_cnt[i] = 0;
                    end else if (req_valid[i] &&
                                 ((dut_acc & (req_op[i] ? req_op : ~req_op)) != '0)) begin
                        wait_cnt[i]++;
                    end
                end
            end

            prev_valid = req_valid;
            prev_ready = req_ready;
            for (int i = 0; i < NREQ; i++)
                prev_req[i] = {req_valid[i], req_op[i], req_a[4*i +: 4], req_b[4*i +: 4]};
            acc_seen = dut_acc;
        end
    end

    task automatic set_req(input int i, input logic op, input logic [3:0] a, input logic [3:0] b);
        req_valid[i]     = 1'b1;
        req_op[i]        = op;
        req_a[4*i +: 4]  = a;
        req_b[4*i +: 4]  = b;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst       = 1'b1;
        req_valid = '0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_add_valid", add_rsp_valid, 1'b0);
        chk("rst_mul_valid", mul_rsp_valid, 1'b0);
        chk("rst_add_id", add_rsp_id, 0);
        chk("rst_mul_id", mul_rsp_id, 0);
        chk("rst_add_grants", add_grants, 0);
        chk("rst_mul_grants", mul_grants, 0);
        chk("rst_ready", req_ready, 0);
        rst    = 1'b0;
        mon_en = 1;

        // Single add 9+7
        set_req(0, OP_ADD, 4'd9, 4'd7);
        @(negedge clk); #1;
        chk("t1_ready", req_ready, 3'b001);
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk); #1;
        chk("t1_valid", add_rsp_valid, 1'b1);
        chk("t1_id", add_rsp_id, 0);
        chk("t1_data", add_rsp_data, 16);

        // Two adders contending: alternate 0,1,0,1
        do_reset();
        set_req(0, OP_ADD, 4'd3, 4'd4);
        set_req(1, OP_ADD, 4'd5, 4'd6);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            chk("t2_ready", req_ready, (k % 2 == 0) ? 3'b001 : 3'b010);
            if (k > 0) begin
                chk("t2_id", add_rsp_id, (k - 1) % 2);
                chk("t2_data", add_rsp_data, ((k - 1) % 2 == 0) ? 7 : 11);
            end
            @(posedge clk); #1;
        end
        req_valid = '0;
        @(negedge clk); #1;
        chk("t2_last_id", add_rsp_id, 1);
        chk("t2_last_data", add_rsp_data, 11);

        // Max operands, add and mul in the same cycle
        do_reset();
        set_req(0, OP_ADD, 4'd15, 4'd15);
        set_req(1, OP_MUL, 4'd15, 4'd15);
        @(negedge clk); #1;
        chk("t3_ready", req_ready, 3'b011);
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk); #1;
        chk("t3_add_data", add_rsp_data, 30);
        chk("t3_add_id", add_rsp_id, 0);
        chk("t3_mul_valid", mul_rsp_valid, 1'b1);
        chk("t3_mul_data", mul_rsp_data, 225);
        chk("t3_mul_id", mul_rsp_id, 1);

        // Mul accepted then reset: response dropped, pointer restarted
        do_reset();
        set_req(1, OP_MUL, 4'd2, 4'd3);
        @(negedge clk); #1;
        chk("t4_ready", req_ready, 3'b010);
        @(posedge clk); #1;
        rst       = 1'b1;
        req_valid = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        set_req(0, OP_MUL, 4'd1, 4'd1);
        set_req(1, OP_MUL, 4'd1, 4'd2);
        set_req(2, OP_MUL, 4'd1, 4'd3);
        @(negedge clk); #1;
        chk("t4_mul_valid", mul_rsp_valid, 1'b0);
        chk("t4_add_grants", add_grants, 0);
        chk("t4_mul_grants", mul_grants, 0);
        chk("t4_ready", req_ready, 3'b001);
        @(posedge clk); #1;
        req_valid = '0;

        // Counter saturation: 20 adds with CNTW=4
        do_reset();
        set_req(0, OP_ADD, 4'd1, 4'd1);
        repeat (20) @(posedge clk);
        #1;
        req_valid = '0;
        @(negedge clk); #1;
        chk("sat_add_grants", add_grants, 15);
        chk("sat_mul_grants", mul_grants, 0);

        // Randomized traffic with occasional mid-run resets
        do_reset();
        rnd_en = 1;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            rst = ($urandom_range(499) == 0);
            for (int i = 0; i < NREQ; i++) begin
                if (!(req_valid[i] && !acc_seen[i])) begin
                    if ($urandom_range(9) < 6)
                        set_req(i, 1'($urandom_range(1)), 4'($urandom_range(15)),
                                4'($urandom_range(15)));
                    else
                        req_valid[i] = 1'b0;
                end
            end
            @(posedge clk); #1;
        end
        rnd_en    = 0;
        rst       = 1'b0;
        req_valid = '0;
        repeat (3) @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/arith_rr_scheduler.md
Name: arith_rr_scheduler

Overview:
- Shares one 4-bit registered adder and one 4-bit registered multiplier among NREQ requesters.
- Each cycle it grants at most one add and at most one mul request, using independent round-robin arbiters.
- It drives the selected operands into the units and tags each result with the requester ID.
- It sits between the stimulus/requester logic and the adder/multiplier pair, which each register their result one clock after sampling their inputs.

Parameters:
- NREQ, 2, number of requesters (2..8).
- IDW, $clog2(NREQ) (min 1), requester ID width.
- CNTW, 16, width of the saturating per-op grant counters.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  NREQ  request pending, one bit per requester.
- req_op  in  NREQ  per requester: 0 = add, 1 = mul.
- req_a  in  4*NREQ  operand A; requester i occupies bits [4i+3:4i].
- req_b  in  4*NREQ  operand B; same packing as req_a.
- req_ready  out  NREQ  accept strobe; transfer occurs when valid & ready.
- add_a, add_b  out  4 each  operands to the adder unit.
- add_res  in  5  adder unit registered result.
- mul_a, mul_b  out  4 each  operands to the multiplier unit.
- mul_res  in  8  multiplier unit registered result.
- add_rsp_valid  out  1  add result valid.
- add_rsp_id  out  IDW  requester that issued the add.
- add_rsp_data  out  5  add result.
- mul_rsp_valid  out  1  mul result valid.
- mul_rsp_id  out  IDW  requester that issued the mul.
- mul_rsp_data  out  8  mul result.
- add_grants  out  CNTW  saturating count of accepted adds.
- mul_grants  out  CNTW  saturating count of accepted muls.

Behaviour:
- Reset:
  - add_rsp_valid = mul_rsp_valid = 0; add/mul_rsp_id = 0; add/mul_grants = 0.
  - Both RR pointers point at requester 0, so requester 0 has highest priority on the first post-reset cycle.
- Request eligibility per cycle: add_req[i] = req_valid[i] & ~req_op[i]; mul_req[i] = req_valid[i] & req_op[i].
- Arbitration:
  - The add arbiter picks the first asserted add_req[i] searching from ptr_add, wrapping at NREQ-1 -> 0. The mul arbiter does the same with ptr_mul.
  - Each arbiter grants at most one requester per cycle. An add grant and a mul grant may occur in the same cycle.
- req_ready is combinational: req_ready[i] = add_gnt[i] | mul_gnt[i]. Ready depends on valid.
- Requester rule: hold op and operands stable while valid and not ready. The bench must flag any violation.
- Operands:
  - add_a/add_b are a combinational mux of the granted requester's operands; 0 when no add grant.
  - mul_a/mul_b follow the same rule for mul.
- Pointer update (on a grant only): ptr <= granted index + 1, wrapping at NREQ. No grant leaves the pointer unchanged. This guarantees starvation freedom: a continuously requesting requester is served within NREQ grants of its op.
- Response tracking:
  - On the edge ending accept cycle T, the block registers add_rsp_valid <= |add_gnt and add_rsp_id <= granted index. Mul does the same.
  - In cycle T+1, add_rsp_data = add_res and mul_rsp_data = mul_res, passed through combinationally.
  - Latency is exactly 1 cycle, with full throughput: one add and one mul per cycle.
  - There is no response backpressure; consumers must always accept.
- Widths:
  - Add result is 5 bits; max 15+15 = 30, so it never overflows.
  - Mul result is 8 bits; max 15*15 = 225.
  - The block does no arithmetic on results.
- Counters: add_grants/mul_grants increment on each accepted add/mul and saturate at 2^CNTW-1 (no wrap).
- rst asserted mid-operation:
  - All in-flight responses are dropped: rsp_valid = 0 in the cycle after rst is sampled.
  - Pointers and counters clear.
  - While rst is high, req_ready = 0 and unit operands = 0.
- Single requester: if only one valid requester exists, it is granted every cycle regardless of pointer position.
- A req_valid that drops before grant is a protocol violation. The block stays deterministic (the request is simply not granted).

Decomposition:
- Package arith_sched_pkg holds:
  - OP_ADD = 1'b0, OP_MUL = 1'b1.
  - OPND_W = 4, ADD_RES_W = 5, MUL_RES_W = 8.
  - An rsp struct typedef {valid, id, data}.
- One sub-module, rr_arbiter (parameter N), is instantiated twice (add, mul):
  - Inputs: req[N], pointer update on grant.
  - Outputs: onehot gnt[N], gnt_idx, any_gnt.

Test Plan:
- Req0 add 9+7, idle otherwise -> req_ready[0]=1 same cycle; next cycle add_rsp_valid=1, id=0, data=16.
- Req0 and req1 both add (3+4, 5+6), held continuously for 4 cycles -> grants alternate 0,1,0,1; responses 7,11,7,11 with ids 0,1,0,1.
- Req0 add 15+15, req1 mul 15*15 in the same cycle -> both ready; next cycle add_rsp data=30 id=0, mul_rsp data=225 id=1.
- Req1 mul 2*3 accepted, rst asserted in the following cycle -> mul_rsp_valid=0 in the cycle after rst is sampled; counters=0; first post-reset contention grants req0.
- CNTW=4 with 20 consecutive adds -> add_grants stops at 15; mul_grants stays 0.
- Random valid/op/operands over 10k cycles with a scoreboard -> every accepted request yields exactly one response at T+1 with the correct id and data; no requester waits more than NREQ grants of its op.
